// File: rtl/d_cache_responder.sv
// d_cache_responder: direct-mapped, blocking, write-through, no-write-allocate
// data cache answering the hazard controller's request interface. Reads hit with
// zero latency; misses refill a whole line from a request/response memory port.
module d_cache_responder #(
    parameter int INDEX_WIDTH = 5,
    parameter int LINE_WORDS  = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic                  in_mem_action,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [ADDR_WIDTH-1:0] in_addr_next,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_we,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_data,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rsp_data
);
    localparam int OFF_W   = $clog2(LINE_WORDS);
    localparam int LINES   = 1 << INDEX_WIDTH;
    localparam int IDX_LSB = OFF_W + 2;
    localparam int TAG_LSB = IDX_LSB + INDEX_WIDTH;
    localparam int TAG_W   = ADDR_WIDTH - TAG_LSB;
    localparam int SLOT_W  = INDEX_WIDTH + OFF_W;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        REFILL_REQ  = 2'd1,
        REFILL_WAIT = 2'd2,
        WRITE_REQ   = 2'd3
    } state_t;

    // Line storage: valid bits are reset, tags and data are not
    logic [LINES-1:0]      valid_q;
    logic [TAG_W-1:0]      tag_q  [LINES];
    logic [DATA_WIDTH-1:0] data_q [LINES*LINE_WORDS];

    state_t                 state_q,    state_d;
    logic [INDEX_WIDTH-1:0] req_idx_q,  req_idx_d;
    logic [OFF_W-1:0]       req_off_q,  req_off_d;
    logic [TAG_W-1:0]       req_tag_q,  req_tag_d;
    logic [ADDR_WIDTH-1:0]  req_addr_q, req_addr_d;
    logic [DATA_WIDTH-1:0]  req_data_q, req_data_d;
    logic                   req_hit_q,  req_hit_d;
    logic [OFF_W-1:0]       beat_q,     beat_d;

    // Request address decode and lookup
    logic [OFF_W-1:0]       off_s;
    logic [INDEX_WIDTH-1:0] idx_s;
    logic [TAG_W-1:0]       tag_s;
    logic                   hit_s;
    logic [DATA_WIDTH-1:0]  rd_word_s;
    logic [ADDR_WIDTH-1:0]  line_addr_s;
    logic [ADDR_WIDTH-1:0]  word_addr_s;
    logic                   unused_s;

    assign off_s       = in_addr[IDX_LSB-1:2];
    assign idx_s       = in_addr[TAG_LSB-1:IDX_LSB];
    assign tag_s       = in_addr[ADDR_WIDTH-1:TAG_LSB];
    assign hit_s       = valid_q[idx_s] && (tag_q[idx_s] == tag_s);
    assign rd_word_s   = data_q[{idx_s, off_s}];
    assign line_addr_s = {in_addr[ADDR_WIDTH-1:IDX_LSB], {IDX_LSB{1'b0}}};
    assign word_addr_s = {in_addr[ADDR_WIDTH-1:2], 2'b00};
    // The next-address hint and byte offset carry no meaning for this cache
    assign unused_s    = ^{in_addr_next, in_addr[1:0]};

    // Single write port into the data array (refill beat or write-hit update)
    logic                  out_valid_s;
    logic [DATA_WIDTH-1:0] out_data_s;
    logic                  fill_done_s;
    logic                  word_we_s;
    logic [SLOT_W-1:0]     word_slot_s;
    logic [DATA_WIDTH-1:0] word_data_s;

    // Next-state, capture and response logic for the cache controller
    always_comb begin
        state_d     = state_q;
        req_idx_d   = req_idx_q;
        req_off_d   = req_off_q;
        req_tag_d   = req_tag_q;
        req_addr_d  = req_addr_q;
        req_data_d  = req_data_q;
        req_hit_d   = req_hit_q;
        beat_d      = beat_q;
        out_valid_s = 1'b0;
        out_data_s  = '0;
        fill_done_s = 1'b0;
        word_we_s   = 1'b0;
        word_slot_s = '0;
        word_data_s = '0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in_mem_action) begin
                        // Writes always go to memory; remember whether the line is cached
                        req_idx_d  = idx_s;
                        req_off_d  = off_s;
                        req_addr_d = word_addr_s;
                        req_data_d = in_data;
                        req_hit_d  = hit_s;
                        state_d    = WRITE_REQ;
                    end else if (hit_s) begin
                        out_valid_s = 1'b1;
                        out_data_s  = rd_word_s;
                    end else begin
                        req_idx_d  = idx_s;
                        req_tag_d  = tag_s;
                        req_addr_d = line_addr_s;
                        state_d    = REFILL_REQ;
                    end
                end else begin
                    // No request: nothing to stall on
                    out_valid_s = 1'b1;
                end
            end
            REFILL_REQ: begin
                if (mem_req_ready) begin
                    state_d = REFILL_WAIT;
                    beat_d  = '0;
                end else begin
                    state_d = REFILL_REQ;
                end
            end
            REFILL_WAIT: begin
                if (mem_rsp_valid) begin
                    word_we_s   = 1'b1;
                    word_slot_s = {req_idx_q, beat_q};
                    word_data_s = mem_rsp_data;
                    if (beat_q == LAST_BEAT) begin
                        // Line is marked valid only once every word has landed
                        fill_done_s = 1'b1;
                        beat_d      = '0;
                        state_d     = IDLE;
                    end else begin
                        beat_d = beat_q + OFF_W'(1);
                    end
                end else begin
                    beat_d = beat_q;
                end
            end
            WRITE_REQ: begin
                if (mem_req_ready) begin
                    out_valid_s = 1'b1;
                    state_d     = IDLE;
                    if (req_hit_q) begin
                        word_we_s   = 1'b1;
                        word_slot_s = {req_idx_q, req_off_q};
                        word_data_s = req_data_q;
                    end else begin
                        word_we_s = 1'b0;
                    end
                end else begin
                    state_d = WRITE_REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller state, request capture and line valid bits
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            req_idx_q  <= '0;
            req_off_q  <= '0;
            req_tag_q  <= '0;
            req_addr_q <= '0;
            req_data_q <= '0;
            req_hit_q  <= 1'b0;
            beat_q     <= '0;
        end else begin
            state_q    <= state_d;
            req_idx_q  <= req_idx_d;
            req_off_q  <= req_off_d;
            req_tag_q  <= req_tag_d;
            req_addr_q <= req_addr_d;
            req_data_q <= req_data_d;
            req_hit_q  <= req_hit_d;
            beat_q     <= beat_d;
            if (fill_done_s) begin
                valid_q[req_idx_q] <= 1'b1;
            end
        end
    end

    // Tag and data arrays; writes suppressed while reset is asserted
    always_ff @(posedge clk) begin
        if (rst_n && fill_done_s) begin
            tag_q[req_idx_q] <= req_tag_q;
        end
        if (rst_n && word_we_s) begin
            data_q[word_slot_s] <= word_data_s;
        end
    end

    assign out_valid     = out_valid_s;
    assign out_data      = out_data_s;
    assign mem_req_valid = (state_q == REFILL_REQ) || (state_q == WRITE_REQ);
    assign mem_req_we    = (state_q == WRITE_REQ);
    assign mem_req_addr  = req_addr_q;
    assign mem_req_data  = req_data_q;

endmodule

// File: tb/tb_d_cache_responder.sv
// Bench for d_cache_responder: table of requests with a memory responder model,
// plus hand-written reset-during-refill and dropped-request sequences.
module tb_d_cache_responder;
    localparam int LW = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_mem_action = 1'b0;
    logic [31:0] in_addr = 32'h0;
    logic [31:0] in_addr_next = 32'h0;
    logic [31:0] in_data = 32'h0;
    logic        out_valid;
    logic [31:0] out_data;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_data;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = 32'h0;

    d_cache_responder #(
        .INDEX_WIDTH(5), .LINE_WORDS(LW), .DATA_WIDTH(32), .ADDR_WIDTH(32)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_mem_action(in_mem_action),
        .in_addr(in_addr), .in_addr_next(in_addr_next), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int ready_delay = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } req_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic        exp_hit;
        int          delay;
    } vec_t;

    logic [31:0] mem_model [int unsigned];
    req_t        req_q [$];
    logic [31:0] exp_q [$];

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        int unsigned k;
        k = a >> 2;
        if (mem_model.exists(k)) return mem_model[k];
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    // Memory side: checks each request against the scoreboard, applies the
    // programmed ready delay and streams refill beats in ascending order.
    initial begin : responder
        int          wait_cnt;
        int          beats_left;
        logic [31:0] beat_addr;
        logic        pending;
        req_t        seen;
        req_t        want;
        wait_cnt = 0; beats_left = 0; beat_addr = 32'h0; pending = 1'b0;
        forever begin
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            mem_req_ready = 1'b0;
            if (!rst_n) begin
                beats_left = 0; pending = 1'b0; wait_cnt = 0;
            end else begin
                if (beats_left > 0) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = rd_mem(beat_addr);
                    beat_addr     = beat_addr + 32'd4;
                    beats_left--;
                end
                if (mem_req_valid) begin
                    if (!pending) begin
                        pending = 1'b1;
                        seen = '{mem_req_we, mem_req_addr, mem_req_data};
                        if (req_q.size() == 0) begin
                            n_cmp++; n_bad++;
                            $display("FAIL mem_req: unexpected request we=%0b addr %h", mem_req_we, mem_req_addr);
                        end else begin
                            want = req_q.pop_front();
                            check("mem_req_we", 32'(mem_req_we), 32'(want.we));
                            check("mem_req_addr", mem_req_addr, want.addr);
                            if (want.we) check("mem_req_data", mem_req_data, want.data);
                        end
                    end else begin
                        check("req_stable_we", 32'(mem_req_we), 32'(seen.we));
                        check("req_stable_addr", mem_req_addr, seen.addr);
                        check("req_stable_data", mem_req_data, seen.data);
                    end
                    if (wait_cnt >= ready_delay) begin
                        mem_req_ready = 1'b1;
                        wait_cnt = 0;
                        pending = 1'b0;
                        if (!seen.we) begin
                            beats_left = LW;
                            beat_addr  = seen.addr;
                        end
                    end else begin
                        wait_cnt++;
                    end
                end
            end
        end
    end

    // One request: drive, wait (bounded) for out_valid, check latency and data
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] data,
                          input logic exp_hit, input int delay, input string name);
        int          cycles;
        int          exp_lat;
        logic [31:0] exp_d;
        @(negedge clk);
        ready_delay   = delay;
        in_valid      = 1'b1;
        in_mem_action = we;
        in_addr       = addr;
        in_addr_next  = addr + 32'd4;
        in_data       = data;
        if (we) begin
            req_q.push_back('{1'b1, addr & 32'hFFFF_FFFC, data});
            mem_model[addr >> 2] = data;
            exp_lat = 1 + delay;
        end else begin
            exp_q.push_back(rd_mem(addr));
            if (exp_hit) begin
                exp_lat = 0;
            end else begin
                exp_lat = 2 + delay + LW;
                req_q.push_back('{1'b0, addr & 32'hFFFF_FFF0, 32'h0});
            end
        end
        cycles = 0;
        #1;
        while (!out_valid && cycles < 100) begin
            @(negedge clk);
            #1;
            cycles++;
        end
        if (!out_valid) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_timeout: out_valid low after %0d cycles, required after %0d", name, cycles, exp_lat);
            exp_q.delete();
        end else begin
            check({name, "_lat"}, cycles, exp_lat);
            if (!we) begin
                exp_d = exp_q.pop_front();
                check({name, "_data"}, out_data, exp_d);
            end
        end
    endtask

    vec_t vecs [16];

    initial begin
        // {we, addr, data, exp_hit, ready delay}
        vecs[0]  = '{1'b0, 32'h0000_0100, 32'h0,          1'b0, 0};
        vecs[1]  = '{1'b0, 32'h0000_0104, 32'h0,          1'b1, 0};
        vecs[2]  = '{1'b0, 32'h0000_010C, 32'h0,          1'b1, 0};
        vecs[3]  = '{1'b1, 32'h0000_0108, 32'hDEAD_BEEF,  1'b1, 3};
        vecs[4]  = '{1'b0, 32'h0000_0108, 32'h0,          1'b1, 0};
        vecs[5]  = '{1'b1, 32'h0000_2000, 32'h1234_5678,  1'b0, 0};
        vecs[6]  = '{1'b0, 32'h0000_2000, 32'h0,          1'b0, 0};
        vecs[7]  = '{1'b0, 32'h0000_0300, 32'h0,          1'b0, 0};
        vecs[8]  = '{1'b0, 32'h0000_0304, 32'h0,          1'b1, 0};
        vecs[9]  = '{1'b0, 32'h0000_0100, 32'h0,          1'b0, 0};
        vecs[10] = '{1'b0, 32'h0000_0108, 32'h0,          1'b1, 0};
        vecs[11] = '{1'b1, 32'h0000_030C, 32'hA5A5_0F0F,  1'b0, 1};
        vecs[12] = '{1'b0, 32'h0000_0104, 32'h0,          1'b1, 0};
        vecs[13] = '{1'b0, 32'h0000_07F0, 32'h0,          1'b0, 2};
        vecs[14] = '{1'b0, 32'h0000_07FC, 32'h0,          1'b1, 0};
        vecs[15] = '{1'b0, 32'h0000_030C, 32'h0,          1'b0, 0};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'h1);
        check("rst_out_data", out_data, 32'h0);
        check("rst_mem_req_valid", 32'(mem_req_valid), 32'h0);
        check("rst_mem_req_we", 32'(mem_req_we), 32'h0);
        check("rst_mem_req_addr", mem_req_addr, 32'h0);
        check("rst_mem_req_data", mem_req_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            do_req(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].exp_hit, vecs[i].delay,
                   $sformatf("vec%0d", i));
        end

        // Reset asserted while refill beat 2 is on the bus
        @(negedge clk);
        ready_delay = 0;
        in_valid = 1'b1; in_mem_action = 1'b0; in_addr = 32'h500; in_addr_next = 32'h504;
        req_q.push_back('{1'b0, 32'h0000_0500, 32'h0});
        #1 check("rstseq_miss_valid", 32'(out_valid), 32'h0);
        @(negedge clk);
        #1;
        check("rstseq_req_valid", 32'(mem_req_valid), 32'h1);
        check("rstseq_req_addr", mem_req_addr, 32'h0000_0500);
        repeat (2) @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        check("rstseq_req_dropped", 32'(mem_req_valid), 32'h0);
        check("rstseq_idle_valid", 32'(out_valid), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        do_req(1'b0, 32'h500, 32'h0, 1'b0, 0, "rstseq_reread");

        // Request withdrawn mid-refill: line still fills, no stale response
        @(negedge clk);
        ready_delay = 0;
        in_valid = 1'b1; in_mem_action = 1'b0; in_addr = 32'h600; in_addr_next = 32'h604;
        req_q.push_back('{1'b0, 32'h0000_0600, 32'h0});
        #1 check("drop_miss_valid", 32'(out_valid), 32'h0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 2) in_valid = 1'b0;
            #1 check($sformatf("drop_busy%0d", k), 32'(out_valid), 32'h0);
        end
        @(negedge clk);
        #1;
        check("drop_idle_valid", 32'(out_valid), 32'h1);
        check("drop_idle_data", out_data, 32'h0);
        do_req(1'b0, 32'h600, 32'h0, 1'b1, 0, "drop_hit");

        @(negedge clk);
        in_valid = 1'b0;
        check("req_q_drained", req_q.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
